otter_io_bridge: RTL and testbench
==================================

Name: otter_io_bridge

Overview:
- Memory-mapped I/O peripheral block directly downstream of the OTTER memory's IO port.
- Consumes the IO write strobe, the data address and the store data for accesses at or above 0x0001_0000.
- Produces the IO read word that the memory buffers into its data output.
- Holds the board switch/button inputs, LED and seven-segment registers, and a compare timer with an interrupt to the CPU.

Parameters:
- SW_WIDTH, 16, number of switch inputs.
- BTN_WIDTH, 5, number of button inputs.
- PRESCALE, 1, clock cycles per timer increment (1 = every cycle); must be ≥1.
- DEBOUNCE_CYCLES, 500000, stable cycles required by the button debouncer (used only with IO_DEBOUNCE_EN).

Ports:
- IO_CLK  in  1  system clock, same clock as the memory.
- IO_RST_N  in  1  asynchronous active-low reset.
- IO_ADDR  in  32  data address; connects to the memory's data address.
- IO_WR  in  1  IO write strobe; connects to the memory's IO write output.
- IO_DIN  in  32  store data; connects to the memory's data-in.
- IO_IN  out  32  combinational read data for IO_ADDR; connects to the memory's IO input.
- SWITCHES  in  SW_WIDTH  raw board switches (asynchronous).
- BUTTONS  in  BTN_WIDTH  raw board buttons (asynchronous).
- LEDS  out  16  LED register.
- SSEG_DATA  out  16  seven-segment display value register.
- INTR  out  1  level interrupt = timer pending AND irq-enable.

Behaviour:
- Address map (word addresses; IO_ADDR[1:0] ignored):
  - 0x1100_0000 SW: RO, zero-extended.
  - 0x1100_0004 BTN: RO, zero-extended.
  - 0x1100_0020 LED: RW, [15:0].
  - 0x1100_0040 SSEG: RW, [15:0].
  - 0x1100_0060 TCNT: RW, 32 bits.
  - 0x1100_0064 TCMP: RW, 32 bits.
  - 0x1100_0068 TCTRL: RW. Bit0 EN, bit1 CLR_ON_MATCH, bit2 IE; upper bits read 0.
  - 0x1100_006C TSTAT: bit0 PEND; read, write-1-to-clear.
- Unmapped addresses: read 0, writes ignored. Writes to RO registers are ignored.
- Writes:
  - Take effect at the IO_CLK rising edge when IO_WR=1.
  - Always full 32-bit; size is not visible to this block; registers narrower than 32 bits take the low bits.
- IO_IN: purely combinational mux on IO_ADDR; zero added latency. The memory's buffer register supplies the one-cycle read latency.
- Input synchronisation:
  - SWITCHES and BUTTONS each pass through a 2-flop synchroniser.
  - SW/BTN reads reflect raw inputs 2 cycles late.
- Reset (async, IO_RST_N=0): all of the following go to 0 immediately.
  - LEDS, SSEG_DATA, TCNT, TCMP, TCTRL, PEND, prescaler, synchroniser flops.
  - Therefore INTR=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1; a tick is issued when it wraps.
  - Held at 0 while EN=0.
  - A write to TCNT also clears it.
- Timer, on a tick:
  - If TCNT==TCMP: set PEND. Then TCNT←0 if CLR_ON_MATCH, else TCNT←TCNT+1.
  - Otherwise TCNT←TCNT+1, wrapping 0xFFFF_FFFF→0 without setting PEND.
- Priority rules:
  - A TCNT write beats the tick increment in the same cycle.
  - A PEND set (match) beats a W1C clear in the same cycle.
  - A TCMP write the same cycle as a tick: the match uses the old TCMP.
- Enable/disable:
  - Clearing EN freezes TCNT; PEND is unaffected.
  - Setting IE while PEND=1 raises INTR on the next cycle.
- Reset mid-count: everything returns to 0 asynchronously. No interrupt is generated on reset release.

Optional Feature:
- IO_DEBOUNCE_EN defined:
  - Each synchronised button passes through a debouncer.
  - An output changes only after the input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - BTN reads return the debounced value.
- Not defined: BTN reads return the 2-flop synchronised value; DEBOUNCE_CYCLES is unused.

Decomposition:
- Package otter_io_pkg:
  - Address constants: ADDR_SW, ADDR_BTN, ADDR_LED, ADDR_SSEG, ADDR_TCNT, ADDR_TCMP, ADDR_TCTRL, ADDR_TSTAT.
  - TCTRL bit indices: CTRL_EN=0, CTRL_CLR=1, CTRL_IE=2.
  - IO base 0x0001_0000.
- Sub-module io_debouncer:
  - One instance per button.
  - Counter plus stable-state register.
  - Instantiated only under IO_DEBOUNCE_EN.

Test Plan:
1. Reset, then write 0x0000_A5A5 to 0x1100_0020 and read it back → LEDS=0xA5A5 at the next edge; IO_IN=0x0000_A5A5 while IO_ADDR=0x1100_0020.
2. SWITCHES=0x1234 → reads of 0x1100_0000 show 0 for 2 cycles, then 0x0000_1234. Read 0x1100_0010 (unmapped) → 0.
3. PRESCALE=1; TCMP=5, TCTRL=0x7 → PEND and INTR rise on the tick where TCNT==5, TCNT becomes 0. Write 0x1 to TSTAT → INTR=0.
4. TCTRL=0x1 (no CLR, IE=0), TCNT=0xFFFF_FFFE, TCMP=3 → TCNT wraps to 0 with no PEND; PEND sets at TCNT==3; INTR stays 0. Then write IE=1 → INTR=1 next cycle.
5. Simultaneous events:
   - W1C to TSTAT in the same cycle as a match → PEND stays 1.
   - TCNT write of 0x100 in a tick cycle → TCNT=0x100, not an increment.
6. Assert IO_RST_N mid-count with INTR=1 → all outputs 0 immediately. With IO_DEBOUNCE_EN: a 3-cycle BUTTONS glitch → BTN reads stay 0.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared constants for the OTTER memory-mapped I/O bridge: address map,
// timer control bit positions and the base of the I/O region.
package otter_io_pkg;

    localparam logic [31:0] IO_BASE    = 32'h0001_0000;

    localparam logic [31:0] ADDR_SW    = 32'h1100_0000;
    localparam logic [31:0] ADDR_BTN   = 32'h1100_0004;
    localparam logic [31:0] ADDR_LED   = 32'h1100_0020;
    localparam logic [31:0] ADDR_SSEG  = 32'h1100_0040;
    localparam logic [31:0] ADDR_TCNT  = 32'h1100_0060;
    localparam logic [31:0] ADDR_TCMP  = 32'h1100_0064;
    localparam logic [31:0] ADDR_TCTRL = 32'h1100_0068;
    localparam logic [31:0] ADDR_TSTAT = 32'h1100_006C;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_IE  = 2;
    localparam int CTRL_W   = 3;

endpackage

// File: rtl/io_debouncer.sv
// Single-bit debouncer: the output follows the input only after the input
// has held a new value for CYCLES consecutive clocks.
module io_debouncer #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_out
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_state;

    // The counter runs only while the input disagrees with the held state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else if (i_in == r_state) begin
            r_cnt   <= '0;
        end else if (r_cnt == CW'(CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= i_in;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_out = r_state;

endmodule

// File: rtl/otter_io_bridge.sv
// OTTER I/O bridge: switches/buttons, LED and 7-seg registers, compare timer
// with interrupt. Define IO_DEBOUNCE_EN to debounce the button inputs.
module otter_io_bridge
    import otter_io_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int BTN_WIDTH       = 5,
    parameter int PRESCALE        = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 IO_CLK,
    input  logic                 IO_RST_N,
    input  logic [31:0]          IO_ADDR,
    input  logic                 IO_WR,
    input  logic [31:0]          IO_DIN,
    output logic [31:0]          IO_IN,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    input  logic [BTN_WIDTH-1:0] BUTTONS,
    output logic [15:0]          LEDS,
    output logic [15:0]          SSEG_DATA,
    output logic                 INTR
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if (PRESCALE < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("otter_io_bridge: PRESCALE and DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SW_WIDTH-1:0]  r_sw_s1, r_sw_s2;
    logic [BTN_WIDTH-1:0] r_btn_s1, r_btn_s2;
    logic [BTN_WIDTH-1:0] w_btn_val;

    logic [15:0]       r_leds, r_sseg;
    logic [31:0]       r_tcnt, r_tcmp;
    logic [CTRL_W-1:0] r_tctrl;
    logic              r_pend;
    logic [PRE_W-1:0]  r_pre;

    logic w_wr, w_wr_led, w_wr_sseg, w_wr_tcnt, w_wr_tcmp, w_wr_tctrl, w_wr_tstat;
    logic w_tick, w_match;
    logic [31:0] w_rdata;

    // Two-flop synchronisers for the asynchronous board inputs.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= SWITCHES;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= BUTTONS;
            r_btn_s2 <= r_btn_s1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_debounce
        io_debouncer #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk   (IO_CLK),
            .rst_n (IO_RST_N),
            .i_in  (r_btn_s2[g]),
            .o_out (w_btn_val[g])
        );
    end
`else
    assign w_btn_val = r_btn_s2;
`endif

    assign w_wr       = IO_WR && (IO_ADDR >= IO_BASE);
    assign w_wr_led   = w_wr && (IO_ADDR[31:2] == ADDR_LED[31:2]);
    assign w_wr_sseg  = w_wr && (IO_ADDR[31:2] == ADDR_SSEG[31:2]);
    assign w_wr_tcnt  = w_wr && (IO_ADDR[31:2] == ADDR_TCNT[31:2]);
    assign w_wr_tcmp  = w_wr && (IO_ADDR[31:2] == ADDR_TCMP[31:2]);
    assign w_wr_tctrl = w_wr && (IO_ADDR[31:2] == ADDR_TCTRL[31:2]);
    assign w_wr_tstat = w_wr && (IO_ADDR[31:2] == ADDR_TSTAT[31:2]);

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_leds  <= '0;
            r_sseg  <= '0;
            r_tcmp  <= '0;
            r_tctrl <= '0;
        end else begin
            if (w_wr_led)   r_leds  <= IO_DIN[15:0];
            if (w_wr_sseg)  r_sseg  <= IO_DIN[15:0];
            if (w_wr_tcmp)  r_tcmp  <= IO_DIN;
            if (w_wr_tctrl) r_tctrl <= IO_DIN[CTRL_W-1:0];
        end
    end

    assign w_tick  = r_tctrl[CTRL_EN] && (r_pre == PRE_W'(PRESCALE - 1));
    assign w_match = w_tick && (r_tcnt == r_tcmp);

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_pre <= '0;
        end else if (!r_tctrl[CTRL_EN] || w_wr_tcnt || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // A software TCNT write wins over the tick; the match still sees old TCMP.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_tcnt <= '0;
        end else if (w_wr_tcnt) begin
            r_tcnt <= IO_DIN;
        end else if (w_tick) begin
            r_tcnt <= (w_match && r_tctrl[CTRL_CLR]) ? 32'd0 : r_tcnt + 32'd1;
        end
    end

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_pend <= 1'b0;
        end else if (w_match) begin
            r_pend <= 1'b1;
        end else if (w_wr_tstat && IO_DIN[0]) begin
            r_pend <= 1'b0;
        end
    end

    // NOTE: the read mux assigns a default before the case so no path leaves
    // w_rdata unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rdata = '0;
        if (IO_ADDR >= IO_BASE) begin
            case (IO_ADDR[31:2])
                ADDR_SW[31:2]:    w_rdata = 32'(r_sw_s2);
                ADDR_BTN[31:2]:   w_rdata = 32'(w_btn_val);
                ADDR_LED[31:2]:   w_rdata = {16'd0, r_leds};
                ADDR_SSEG[31:2]:  w_rdata = {16'd0, r_sseg};
                ADDR_TCNT[31:2]:  w_rdata = r_tcnt;
                ADDR_TCMP[31:2]:  w_rdata = r_tcmp;
                ADDR_TCTRL[31:2]: w_rdata = {{(32 - CTRL_W){1'b0}}, r_tctrl};
                ADDR_TSTAT[31:2]: w_rdata = {31'd0, r_pend};
                default:          w_rdata = '0;
            endcase
        end
    end

    assign IO_IN     = w_rdata;
    assign LEDS      = r_leds;
    assign SSEG_DATA = r_sseg;
    assign INTR      = r_pend & r_tctrl[CTRL_IE];

endmodule

// File: tb/tb_otter_io_bridge.sv
// Scoreboard bench for otter_io_bridge: a cycle-level register model predicts
// IO_IN, LEDS, SSEG_DATA and INTR; a negedge monitor compares them.
module tb_otter_io_bridge;

    localparam int TB_PRESCALE = 1;
    localparam int TB_DEBOUNCE = 8;

    localparam logic [31:0] A_SW    = 32'h1100_0000;
    localparam logic [31:0] A_BTN   = 32'h1100_0004;
    localparam logic [31:0] A_UNMAP = 32'h1100_0010;
    localparam logic [31:0] A_LED   = 32'h1100_0020;
    localparam logic [31:0] A_SSEG  = 32'h1100_0040;
    localparam logic [31:0] A_TCNT  = 32'h1100_0060;
    localparam logic [31:0] A_TCMP  = 32'h1100_0064;
    localparam logic [31:0] A_TCTRL = 32'h1100_0068;
    localparam logic [31:0] A_TSTAT = 32'h1100_006C;
    localparam logic [31:0] A_LOW   = 32'h0000_0020;

    logic        IO_CLK   = 1'b0;
    logic        IO_RST_N = 1'b0;
    logic [31:0] IO_ADDR  = '0;
    logic        IO_WR    = 1'b0;
    logic [31:0] IO_DIN   = '0;
    logic [31:0] IO_IN;
    logic [15:0] SWITCHES = '0;
    logic [4:0]  BUTTONS  = '0;
    logic [15:0] LEDS;
    logic [15:0] SSEG_DATA;
    logic        INTR;

    otter_io_bridge #(
        .SW_WIDTH        (16),
        .BTN_WIDTH       (5),
        .PRESCALE        (TB_PRESCALE),
        .DEBOUNCE_CYCLES (TB_DEBOUNCE)
    ) dut (
        .IO_CLK    (IO_CLK),
        .IO_RST_N  (IO_RST_N),
        .IO_ADDR   (IO_ADDR),
        .IO_WR     (IO_WR),
        .IO_DIN    (IO_DIN),
        .IO_IN     (IO_IN),
        .SWITCHES  (SWITCHES),
        .BUTTONS   (BUTTONS),
        .LEDS      (LEDS),
        .SSEG_DATA (SSEG_DATA),
        .INTR      (INTR)
    );

    always #5 IO_CLK = ~IO_CLK;

    typedef struct {
        string       tag;
        logic [31:0] io_in;
        logic [15:0] leds;
        logic [15:0] sseg;
        logic        intr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Register-level model of the peripheral as software sees it.
    logic [15:0] m_leds, m_sseg, m_sw1, m_sw2;
    logic [31:0] m_tcnt, m_tcmp;
    logic [2:0]  m_ctrl;
    logic        m_pend;
    logic [4:0]  m_btn1, m_btn2;
    int          m_pre;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_leds = '0; m_sseg = '0; m_tcnt = '0; m_tcmp = '0;
        m_ctrl = '0; m_pend = 1'b0; m_pre = 0;
        m_sw1 = '0; m_sw2 = '0; m_btn1 = '0; m_btn2 = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            A_SW:    return {16'd0, m_sw2};
`ifdef IO_DEBOUNCE_EN
            A_BTN:   return 32'd0;
`else
            A_BTN:   return {27'd0, m_btn2};
`endif
            A_LED:   return {16'd0, m_leds};
            A_SSEG:  return {16'd0, m_sseg};
            A_TCNT:  return m_tcnt;
            A_TCMP:  return m_tcmp;
            A_TCTRL: return {29'd0, m_ctrl};
            A_TSTAT: return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic [31:0] wa;
        logic        tick, match;
        logic [31:0] n_tcnt;
        logic        n_pend;
        int          n_pre;
        wa     = {a[31:2], 2'b00};
        tick   = m_ctrl[0] && (m_pre == TB_PRESCALE - 1);
        match  = tick && (m_tcnt == m_tcmp);
        n_tcnt = m_tcnt;
        n_pend = m_pend;
        n_pre  = (!m_ctrl[0] || tick) ? 0 : m_pre + 1;
        if (tick) n_tcnt = (match && m_ctrl[1]) ? 32'd0 : m_tcnt + 32'd1;
        if (match) n_pend = 1'b1;
        else if (w && wa == A_TSTAT && d[0]) n_pend = 1'b0;
        if (w) begin
            case (wa)
                A_LED:   m_leds = d[15:0];
                A_SSEG:  m_sseg = d[15:0];
                A_TCNT:  begin n_tcnt = d; n_pre = 0; end
                A_TCMP:  m_tcmp = d;
                A_TCTRL: m_ctrl = d[2:0];
                default: ;
            endcase
        end
        m_tcnt = n_tcnt;
        m_pend = n_pend;
        m_pre  = n_pre;
        m_sw2  = m_sw1;
        m_sw1  = SWITCHES;
        m_btn2 = m_btn1;
        m_btn1 = BUTTONS;
    endfunction

    // One bus cycle: drive, predict, let the monitor compare at negedge.
    task automatic cycle(input logic [31:0] a, input logic w, input logic [31:0] d, input string tag);
        exp_t e;
        IO_ADDR = a;
        IO_WR   = w;
        IO_DIN  = d;
        e.tag   = tag;
        e.io_in = model_read(a);
        e.leds  = m_leds;
        e.sseg  = m_sseg;
        e.intr  = m_pend & m_ctrl[2];
        sb.push_back(e);
        @(posedge IO_CLK);
        if (IO_RST_N) model_step(a, w, d);
        else          model_reset();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        cycle(a, 1'b1, d, tag);
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        cycle(a, 1'b0, 32'd0, tag);
    endtask

    exp_t mon_e;
    always @(negedge IO_CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, ".io_in"}, IO_IN, mon_e.io_in);
            check({mon_e.tag, ".leds"}, {16'd0, LEDS}, {16'd0, mon_e.leds});
            check({mon_e.tag, ".sseg"}, {16'd0, SSEG_DATA}, {16'd0, mon_e.sseg});
            check({mon_e.tag, ".intr"}, {31'd0, INTR}, {31'd0, mon_e.intr});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addrs [10];
        addrs = '{A_SW, A_BTN, A_LED, A_SSEG, A_TCNT, A_TCMP, A_TCTRL, A_TSTAT, A_UNMAP, A_LOW};
        model_reset();
        repeat (2) @(posedge IO_CLK);
        #1;
        rd(A_LED, "reset_led");
        rd(A_TCTRL, "reset_tctrl");
        IO_RST_N = 1'b1;

        // LED write and read-back
        wr(A_LED, 32'h0000_A5A5, "t1_wr_led");
        rd(A_LED, "t1_rd_led");
        wr(A_SSEG, 32'hFFFF_1234, "t1_wr_sseg");
        wr(A_SW, 32'hFFFF_FFFF, "t1_wr_ro");

        // Switch synchroniser latency and unmapped read
        SWITCHES = 16'h1234;
        for (int i = 0; i < 4; i++) rd(A_SW, "t2_sw");
        rd(A_UNMAP, "t2_unmapped");

        // Buttons
`ifdef IO_DEBOUNCE_EN
        BUTTONS = 5'h01;
        for (int i = 0; i < 3; i++) rd(A_BTN, "t6_glitch");
        BUTTONS = 5'h00;
        for (int i = 0; i < 12; i++) rd(A_BTN, "t6_glitch_after");
`else
        BUTTONS = 5'h15;
        for (int i = 0; i < 4; i++) rd(A_BTN, "t2_btn");
        BUTTONS = 5'h00;
        for (int i = 0; i < 3; i++) rd(A_BTN, "t2_btn_rel");
`endif

        // Match with clear-on-match and interrupt
        wr(A_TCMP, 32'd5, "t3_tcmp");
        wr(A_TCTRL, 32'h7, "t3_tctrl");
        for (int i = 0; i < 20 && !m_pend; i++) rd(A_TCNT, "t3_count");
        rd(A_TCNT, "t3_after_match");
        rd(A_TSTAT, "t3_pend");
        wr(A_TSTAT, 32'h1, "t3_w1c");
        rd(A_TSTAT, "t3_cleared");
        wr(A_TCTRL, 32'h0, "t3_stop");

        // Wrap without PEND, later match with IE off, then IE on
        wr(A_TSTAT, 32'h1, "t4_clr");
        wr(A_TCNT, 32'hFFFF_FFFE, "t4_tcnt");
        wr(A_TCMP, 32'd3, "t4_tcmp");
        wr(A_TCTRL, 32'h1, "t4_en");
        for (int i = 0; i < 12 && !m_pend; i++) rd(A_TCNT, "t4_count");
        rd(A_TSTAT, "t4_pend");
        wr(A_TCTRL, 32'h5, "t4_ie");
        rd(A_TSTAT, "t4_intr");

        // W1C in the match cycle loses to the match
        wr(A_TCTRL, 32'h0, "t5_stop");
        wr(A_TSTAT, 32'h1, "t5_clr");
        wr(A_TCNT, 32'd0, "t5_tcnt");
        wr(A_TCMP, 32'd2, "t5_tcmp");
        wr(A_TCTRL, 32'h1, "t5_en");
        for (int i = 0; i < 10 && m_tcnt != m_tcmp; i++) rd(A_TCNT, "t5_count");
        wr(A_TSTAT, 32'h1, "t5_w1c_vs_match");
        rd(A_TSTAT, "t5_pend_kept");
        // TCNT write in a tick cycle
        wr(A_TCNT, 32'h100, "t5_tcnt_wr");
        rd(A_TCNT, "t5_tcnt_after");
        // TCMP write in the match cycle: old TCMP decides
        wr(A_TSTAT, 32'h1, "t5_clr2");
        wr(A_TCMP, m_tcnt + 32'd4, "t5_tcmp2");
        for (int i = 0; i < 10 && m_tcnt != m_tcmp; i++) rd(A_TCNT, "t5_count2");
        wr(A_TCMP, 32'hDEAD_0000, "t5_tcmp_vs_match");
        rd(A_TSTAT, "t5_pend_old_tcmp");

        // Randomised register traffic
        for (int n = 0; n < 300; n++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) SWITCHES = 16'($urandom);
            case (op)
                0: wr(A_LED, $urandom, "rnd_led");
                1: wr(A_SSEG, $urandom, "rnd_sseg");
                2: wr(A_TCNT, $urandom_range(0, 15), "rnd_tcnt");
                3: wr(A_TCMP, $urandom_range(0, 15), "rnd_tcmp");
                4: wr(A_TCTRL, $urandom, "rnd_tctrl");
                5: wr(A_TSTAT, $urandom, "rnd_tstat");
                6: wr(addrs[$urandom_range(0, 1)], $urandom, "rnd_wr_ro");
                7: wr(addrs[$urandom_range(8, 9)], $urandom, "rnd_wr_unmapped");
                default: rd(addrs[$urandom_range(0, 9)] | 32'($urandom_range(0, 3)), "rnd_rd");
            endcase
        end

        // Async reset with INTR asserted
        wr(A_TCTRL, 32'h0, "t6_stop");
        wr(A_LED, 32'h0000_00FF, "t6_led");
        wr(A_TCNT, 32'd7, "t6_tcnt");
        wr(A_TCMP, 32'd9, "t6_tcmp");
        wr(A_TCTRL, 32'h7, "t6_run");
        for (int i = 0; i < 10 && !m_pend; i++) rd(A_TCNT, "t6_count");
        rd(A_TSTAT, "t6_intr_high");
        IO_RST_N = 1'b0;
        model_reset();
        rd(A_TCNT, "t6_rst_async");
        rd(A_TSTAT, "t6_rst_hold");
        IO_RST_N = 1'b1;
        for (int i = 0; i < 4; i++) rd(A_TCNT, "t6_post_rst");

        @(negedge IO_CLK);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
